// File: rtl/ppe_pkg.sv
// rtl/ppe_pkg.sv - shared opcodes, packet layout and FSM states for the partial PE
package ppe_pkg;

  localparam int PKG_ADDR_W = 4;
  localparam int PKG_DATA_W = 25;

  localparam logic OP_WEIGHT = 1'b0;
  localparam logic OP_INPUT  = 1'b1;

  localparam int IMEM_ID_DEF = 10;

  typedef struct packed {
    logic [PKG_ADDR_W-1:0] addr;
    logic                  opcode;
    logic [PKG_DATA_W-1:0] data;
  } ppe_pkt_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_SEND_PS,
    ST_SEND_REQ
  } ppe_state_t;

endpackage

// File: rtl/ppe_mac.sv
// rtl/ppe_mac.sv - registered accumulator adding a signed weight when the input bit is set
module ppe_mac #(
  parameter int WEIGHT_W = 8,
  parameter int SUM_W    = 13
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       en,
  input  logic                       tap_bit,
  input  logic signed [WEIGHT_W-1:0] weight,
  output logic signed [SUM_W-1:0]    acc
);

  logic signed [SUM_W-1:0] term;

  assign term = tap_bit ? SUM_W'(weight) : '0;

  // Accumulate one tap per enabled cycle; clear wins so a new window starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + term;
    end
  end

endmodule

// File: rtl/ppe_stream.sv
// rtl/ppe_stream.sv - partial PE: weight row store, sliding-window MAC, SPE/I_MEM packet egress
module ppe_stream
  import ppe_pkg::*;
#(
  parameter int FILTER_SIZE     = 5,
  parameter int IFMAP_SIZE      = 25,
  parameter int WEIGHT_W        = 8,
  parameter int WEIGHTS_PER_PKT = 2,
  parameter int SUM_W           = 13,
  parameter int NUM_SPE         = 5,
  parameter int SPE_BASE        = 0,
  parameter int IMEM_ID         = IMEM_ID_DEF,
  parameter int ADDR_W          = 4,
  parameter int DATA_W          = 25
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W+DATA_W:0]   in_packet,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W+DATA_W:0]   out_packet,
  output logic                     busy,
  output logic                     err
);

  localparam int PKT_W   = ADDR_W + 1 + DATA_W;
  localparam int OUT_DIM = IFMAP_SIZE - FILTER_SIZE + 1;
  localparam int CNT_W   = $clog2(FILTER_SIZE + 1);
  localparam int KW      = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
  localparam int IDX_W   = (IFMAP_SIZE > 1) ? $clog2(IFMAP_SIZE) : 1;

  ppe_state_t state, state_nxt;

  logic                       in_op;
  logic [DATA_W-1:0]          in_data;
  logic                       unused_addr;

  logic [CNT_W-1:0]           wcnt, wcnt_nxt, wbase;
  logic                       wfull;
  logic signed [WEIGHT_W-1:0] weights [FILTER_SIZE];

  logic [IFMAP_SIZE-1:0]      ifmap;
  logic [IDX_W-1:0]           j;
  logic [KW-1:0]              k;
  logic [IDX_W-1:0]           tap_idx;
  logic [ADDR_W-1:0]          spe_ptr;

  logic                       wt_acc, in_acc, drop;
  logic                       last_tap, last_win, ps_xfer;
  logic signed [SUM_W-1:0]    acc;

  assign in_op       = in_packet[DATA_W];
  assign in_data     = in_packet[DATA_W-1:0];
  assign unused_addr = ^in_packet[PKT_W-1:DATA_W+1];

  assign wfull  = (wcnt == CNT_W'(FILTER_SIZE));
  assign wt_acc = (state == ST_IDLE) && in_valid && (in_op == OP_WEIGHT);
  assign in_acc = (state == ST_IDLE) && in_valid && (in_op == OP_INPUT) && wfull;
  assign drop   = (state == ST_IDLE) && in_valid && (in_op == OP_INPUT) && !wfull;

  assign last_tap = (k == KW'(FILTER_SIZE - 1));
  assign last_win = (j == IDX_W'(OUT_DIM - 1));
  assign ps_xfer  = (state == ST_SEND_PS) && out_ready;
  assign tap_idx  = j + IDX_W'(k);

  // A weight packet arriving on a full row restarts the load at slot 0.
  always_comb begin
    int wsum;
    wbase    = wfull ? '0 : wcnt;
    wsum     = int'(wbase) + WEIGHTS_PER_PKT;
    wcnt_nxt = (wsum >= FILTER_SIZE) ? CNT_W'(FILTER_SIZE) : CNT_W'(wsum);
  end

  // Weight storage: packet lane s lands in slot wbase+s, lanes past the row end are dropped.
  always_ff @(posedge clk) begin
    if (wt_acc) begin
      for (int i = 0; i < FILTER_SIZE; i++) begin
        for (int s = 0; s < WEIGHTS_PER_PKT; s++) begin
          if (int'(wbase) + s == i) begin
            weights[i] <= in_data[s*WEIGHT_W +: WEIGHT_W];
          end
        end
      end
    end
  end

  // Weight count and the one-cycle drop indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
      err  <= 1'b0;
    end else begin
      err <= drop;
      if (wt_acc) begin
        wcnt <= wcnt_nxt;
      end
    end
  end

  // Row latch, window/tap counters and SPE rotation (the pointer persists across rows).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifmap   <= '0;
      j       <= '0;
      k       <= '0;
      spe_ptr <= '0;
    end else begin
      if (in_acc) begin
        ifmap <= in_data[IFMAP_SIZE-1:0];
        j     <= '0;
        k     <= '0;
      end
      if (state == ST_MAC) begin
        k <= last_tap ? '0 : k + KW'(1);
      end
      if (ps_xfer) begin
        spe_ptr <= (spe_ptr == ADDR_W'(NUM_SPE - 1)) ? '0 : spe_ptr + ADDR_W'(1);
        j       <= last_win ? '0 : j + IDX_W'(1);
      end
    end
  end

  ppe_mac #(
    .WEIGHT_W (WEIGHT_W),
    .SUM_W    (SUM_W)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (in_acc || ps_xfer),
    .en      (state == ST_MAC),
    .tap_bit (ifmap[tap_idx]),
    .weight  (weights[k]),
    .acc     (acc)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake/packet outputs; outputs derive from registers so they hold under backpressure.
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    out_packet = '0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_acc) begin
          state_nxt = ST_MAC;
        end
      end
      ST_MAC: begin
        if (last_tap) begin
          state_nxt = ST_SEND_PS;
        end
      end
      ST_SEND_PS: begin
        out_valid  = 1'b1;
        out_packet = {ADDR_W'(SPE_BASE) + spe_ptr, OP_WEIGHT, DATA_W'(acc)};
        if (out_ready) begin
          state_nxt = last_win ? ST_SEND_REQ : ST_MAC;
        end
      end
      ST_SEND_REQ: begin
        out_valid  = 1'b1;
        out_packet = {ADDR_W'(IMEM_ID), OP_WEIGHT, {DATA_W{1'b0}}};
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
